lsu_mem_init: RTL and testbench

// - Load/store initiator that converts core load/store ops into data_mem LSU-port transactions.
// - Sits between the execute stage and data_mem. Drives VALID, ADDR, WDATA, BMASK and WREN, and waits for READY.
// - Aligns store data into byte lanes; extracts and sign/zero-extends load data.
// - Stalls the core while a transaction is pending.
// - Flags misaligned, illegal, out-of-range and timed-out accesses.

---
 rtl/singlecycle_pkg.sv | 31 +++
 rtl/lsu_align.sv | 48 ++++
 rtl/lsu_mem_init.sv | 144 ++++++++++++++
 tb/tb_lsu_mem_init.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/singlecycle_pkg.sv
// Shared LSU definitions: RV32I load/store funct3 codes, byte-mask constants,
// FSM state type and the request legality check.
package singlecycle_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] BMASK_B = 4'b0001;
  localparam logic [3:0] BMASK_H = 4'b0011;
  localparam logic [3:0] BMASK_W = 4'b1111;

  typedef enum logic [1:0] {IDLE, REQ, RESP} lsu_state_e;

  // Exactly one of ld/st, a funct3 that exists for that op, and natural alignment.
  function automatic logic req_legal(input logic       ld,
                                     input logic       st,
                                     input logic [2:0] f3,
                                     input logic [1:0] a_lo);
    logic f3_ok;
    logic aligned;
    f3_ok   = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
              (ld && ((f3 == F3_BU) || (f3 == F3_HU)));
    aligned = !(((f3[1:0] == 2'b01) && a_lo[0]) ||
                ((f3[1:0] == 2'b10) && (a_lo != 2'b00)));
    return (ld ^ st) && f3_ok && aligned;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane handling: store-data replication with byte mask, and
// load-lane extraction with sign/zero extension.
module lsu_align
  import singlecycle_pkg::*;
(
  input  logic [2:0]  st_funct3_i,
  input  logic [1:0]  st_addr_lo_i,
  input  logic [31:0] st_wdata_i,
  output logic [31:0] st_wdata_o,
  output logic [3:0]  st_bmask_o,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_addr_lo_i,
  input  logic [31:0] ld_word_i,
  output logic [31:0] ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_wdata_o = st_wdata_i;
    st_bmask_o = BMASK_W;
    case (st_funct3_i[1:0])
      2'b00: begin
        st_wdata_o = {4{st_wdata_i[7:0]}};
        st_bmask_o = BMASK_B << st_addr_lo_i;
      end
      2'b01: begin
        st_wdata_o = {2{st_wdata_i[15:0]}};
        st_bmask_o = BMASK_H << st_addr_lo_i;
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = 8'(ld_word_i >> {ld_addr_lo_i, 3'b000});
    ld_half = ld_addr_lo_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];
    case (ld_funct3_i)
      F3_B:    ld_data_o = {{24{ld_byte[7]}}, ld_byte};
      F3_H:    ld_data_o = {{16{ld_half[15]}}, ld_half};
      F3_BU:   ld_data_o = {24'h0, ld_byte};
      F3_HU:   ld_data_o = {16'h0, ld_half};
      default: ld_data_o = ld_word_i;
    endcase
  end

endmodule

// File: rtl/lsu_mem_init.sv
// Load/store initiator: turns core load/store pulses into data_mem VALID/READY
// transactions, stalls the core while pending and flags bad or timed-out accesses.
module lsu_mem_init
  import singlecycle_pkg::*;
#(
  parameter int unsigned ADDR_W      = 18,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_LD_REQ,
  input  logic              i_ST_REQ,
  input  logic [2:0]        i_FUNCT3,
  input  logic [31:0]       i_ADDR,
  input  logic [31:0]       i_WDATA,
  output logic [31:0]       o_LD_DATA,
  output logic              o_DONE,
  output logic              o_STALL,
  output logic              o_ERR,
  output logic [ADDR_W-1:0] o_MEM_ADDR,
  output logic [31:0]       o_MEM_WDATA,
  output logic [3:0]        o_MEM_BMASK,
  output logic              o_MEM_WREN,
  output logic              o_MEM_VALID,
  input  logic              i_MEM_READY,
  input  logic [31:0]       i_MEM_RDATA
);

  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [3:0]        bmask_q, bmask_d;
  logic              wren_q, wren_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              err_q, err_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;

  logic        req;
  logic        req_ok;
  logic        timeout_hit;
  logic [31:0] st_wdata;
  logic [3:0]  st_bmask;
  logic [31:0] ld_ext;

  lsu_align u_align (
    .st_funct3_i  (i_FUNCT3),
    .st_addr_lo_i (i_ADDR[1:0]),
    .st_wdata_i   (i_WDATA),
    .st_wdata_o   (st_wdata),
    .st_bmask_o   (st_bmask),
    .ld_funct3_i  (funct3_q),
    .ld_addr_lo_i (addr_q[1:0]),
    .ld_word_i    (rdata_q),
    .ld_data_o    (ld_ext)
  );

  assign req         = i_LD_REQ | i_ST_REQ;
  assign req_ok      = req_legal(i_LD_REQ, i_ST_REQ, i_FUNCT3, i_ADDR[1:0]) &&
                       ((i_ADDR >> ADDR_W) == 32'd0);
  assign timeout_hit = (TIMEOUT_CYC != 0) && ((32'(tcnt_q) + 32'd1) >= TIMEOUT_CYC);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      bmask_q  <= '0;
      wren_q   <= 1'b0;
      funct3_q <= '0;
      err_q    <= 1'b0;
      tcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      bmask_q  <= bmask_d;
      wren_q   <= wren_d;
      funct3_q <= funct3_d;
      err_q    <= err_d;
      tcnt_q   <= tcnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    bmask_d  = bmask_q;
    wren_d   = wren_q;
    funct3_d = funct3_q;
    err_d    = 1'b0;
    tcnt_d   = tcnt_q;
    case (state_q)
      IDLE: begin
        if (req && req_ok) begin
          state_d  = REQ;
          addr_d   = i_ADDR[ADDR_W-1:0];
          funct3_d = i_FUNCT3;
          wren_d   = i_ST_REQ;
          wdata_d  = i_ST_REQ ? st_wdata : '0;
          bmask_d  = i_ST_REQ ? st_bmask : BMASK_W;
          tcnt_d   = '0;
        end else if (req) begin
          err_d = 1'b1;
        end
      end
      REQ: begin
        // READY on the final allowed cycle still completes; timeout only without it.
        if (i_MEM_READY) begin
          state_d = RESP;
          rdata_d = i_MEM_RDATA;
          tcnt_d  = '0;
        end else if (timeout_hit) begin
          state_d = IDLE;
          err_d   = 1'b1;
          tcnt_d  = '0;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_MEM_VALID = (state_q == REQ);
    o_MEM_ADDR  = addr_q;
    o_MEM_WDATA = wdata_q;
    o_MEM_BMASK = bmask_q;
    o_MEM_WREN  = wren_q;
    o_DONE      = (state_q == RESP);
    o_LD_DATA   = ((state_q == RESP) && !wren_q) ? ld_ext : '0;
    o_STALL     = ((state_q == IDLE) && req && req_ok) || (state_q == REQ);
    o_ERR       = err_q;
  end

endmodule

// File: tb/tb_lsu_mem_init.sv
// Scoreboarded bench for lsu_mem_init: directed requests push expected memory
// transactions and core responses; a responder and a monitor pop and compare.
module tb_lsu_mem_init;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_LD_REQ, i_ST_REQ;
  logic [2:0]  i_FUNCT3;
  logic [31:0] i_ADDR, i_WDATA;
  logic [31:0] o_LD_DATA;
  logic        o_DONE, o_STALL, o_ERR;
  logic [17:0] o_MEM_ADDR;
  logic [31:0] o_MEM_WDATA;
  logic [3:0]  o_MEM_BMASK;
  logic        o_MEM_WREN, o_MEM_VALID;
  logic        i_MEM_READY;
  logic [31:0] i_MEM_RDATA;

  lsu_mem_init #(.ADDR_W(18), .TIMEOUT_CYC(4)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_LD_REQ    (i_LD_REQ),
    .i_ST_REQ    (i_ST_REQ),
    .i_FUNCT3    (i_FUNCT3),
    .i_ADDR      (i_ADDR),
    .i_WDATA     (i_WDATA),
    .o_LD_DATA   (o_LD_DATA),
    .o_DONE      (o_DONE),
    .o_STALL     (o_STALL),
    .o_ERR       (o_ERR),
    .o_MEM_ADDR  (o_MEM_ADDR),
    .o_MEM_WDATA (o_MEM_WDATA),
    .o_MEM_BMASK (o_MEM_BMASK),
    .o_MEM_WREN  (o_MEM_WREN),
    .o_MEM_VALID (o_MEM_VALID),
    .i_MEM_READY (i_MEM_READY),
    .i_MEM_RDATA (i_MEM_RDATA)
  );

  always #5 i_clk = ~i_clk;

  int unsigned cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    logic [17:0] addr;
    logic [31:0] wdata;
    logic [3:0]  bmask;
    logic        wren;
    int unsigned delay;
    logic [31:0] rdata;
    int unsigned vcycles;
  } mem_exp_t;

  typedef struct {
    bit          err;
    bit          chk_data;
    logic [31:0] data;
    int unsigned due;
  } resp_exp_t;

  mem_exp_t  mem_q[$];
  resp_exp_t resp_q[$];
  int        checks = 0;
  int        errors = 0;
  bit        active = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Memory responder: checks payload on every VALID cycle, answers after 'delay' waits.
  initial begin
    mem_exp_t    cur;
    int unsigned vcnt;
    i_MEM_READY = 1'b0;
    i_MEM_RDATA = '0;
    vcnt = 0;
    forever begin
      @(negedge i_clk);
      if (o_MEM_VALID) begin
        if (!active) begin
          if (mem_q.size() == 0) begin
            chk("unexpected_valid", 1, 0);
          end else begin
            cur    = mem_q.pop_front();
            active = 1;
            vcnt   = 0;
          end
        end
        if (active) begin
          chk("mem_addr", o_MEM_ADDR, cur.addr);
          chk("mem_bmask", o_MEM_BMASK, cur.bmask);
          chk("mem_wren", o_MEM_WREN, cur.wren);
          if (cur.wren) chk("mem_wdata", o_MEM_WDATA, cur.wdata);
          chk("stall_in_req", o_STALL, 1);
          vcnt++;
          i_MEM_READY = (vcnt == cur.delay + 1);
          i_MEM_RDATA = (vcnt == cur.delay + 1) ? cur.rdata : 32'h5A5A_1234;
        end
      end else begin
        i_MEM_READY = 1'b0;
        if (active) begin
          chk("valid_cycles", vcnt, cur.vcycles);
          active = 0;
        end
      end
    end
  end

  // Response monitor.
  initial begin
    resp_exp_t r;
    forever begin
      @(negedge i_clk);
      if (o_DONE || o_ERR) begin
        if (resp_q.size() == 0) begin
          chk("unexpected_resp", {o_ERR, o_DONE}, 0);
        end else begin
          r = resp_q.pop_front();
          chk("resp_kind", {o_ERR, o_DONE}, r.err ? 2'b10 : 2'b01);
          chk("resp_cycle", cyc, r.due);
          if (r.chk_data) chk("ld_data", o_LD_DATA, r.data);
          if (o_DONE) chk("stall_on_done", o_STALL, 0);
        end
      end
    end
  end

  // lat = cycles from the request cycle to o_DONE/o_ERR (0: no response);
  // vcyc = expected VALID cycles (0: no memory transaction).
  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input int unsigned delay, input logic [31:0] rdata,
                       input logic [31:0] exp_wd, input logic [3:0] exp_bm,
                       input int unsigned vcyc, input int unsigned lat,
                       input bit err, input logic [31:0] exp_ld);
    mem_exp_t  m;
    resp_exp_t r;
    @(negedge i_clk);
    i_LD_REQ = ld; i_ST_REQ = st; i_FUNCT3 = f3; i_ADDR = addr; i_WDATA = wd;
    if (vcyc > 0) begin
      m.addr = addr[17:0]; m.wdata = exp_wd; m.bmask = exp_bm; m.wren = st;
      m.delay = delay; m.rdata = rdata; m.vcycles = vcyc;
      mem_q.push_back(m);
    end
    if (lat > 0) begin
      r.err = err; r.chk_data = ld && !err; r.data = exp_ld; r.due = cyc + lat;
      resp_q.push_back(r);
    end
    #1;
    chk("req_stall", o_STALL, (vcyc > 0) ? 1 : 0);
    chk("req_no_valid", o_MEM_VALID, 0);
    @(negedge i_clk);
    i_LD_REQ = 0; i_ST_REQ = 0;
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge i_clk);
      #1;
      if (resp_q.size() == 0 && mem_q.size() == 0 && !active && !o_STALL && !o_MEM_VALID) begin
        ok = 1;
        break;
      end
    end
    chk("drain_timeout", ok, 1);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_ld_data"}, o_LD_DATA, 0);
    chk({name, "_mem_wdata"}, o_MEM_WDATA, 0);
    chk({name, "_misc"}, {o_MEM_ADDR, o_MEM_BMASK, o_MEM_WREN, o_MEM_VALID,
                          o_DONE, o_STALL, o_ERR}, 0);
  endtask

  initial begin
    i_rst_n = 0; i_LD_REQ = 0; i_ST_REQ = 0; i_FUNCT3 = 0; i_ADDR = 0; i_WDATA = 0;
    #23;
    chk_all_zero("reset");
    i_rst_n = 1;
    repeat (2) @(negedge i_clk);

    //     ld st f3      addr          wdata         dly rdata         exp_wd        bm       vc lat err exp_ld
    issue(0, 1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 0, 32'h0,        32'hDEAD_BEEF, 4'b1111, 1, 2, 0, 32'h0);
    drain();
    // SB with slow READY; a load pulse during REQ must be ignored.
    issue(0, 1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 3, 32'h0,        32'hA5A5_A5A5, 4'b1000, 4, 5, 0, 32'h0);
    i_LD_REQ = 1; i_FUNCT3 = 3'b010; i_ADDR = 32'h0000_0200;
    @(negedge i_clk);
    i_LD_REQ = 0;
    drain();
    issue(1, 0, 3'b000, 32'h0000_0101, 32'h0,        0, 32'h0000_8000, 32'h0,        4'b1111, 1, 2, 0, 32'hFFFF_FF80);
    drain();
    issue(1, 0, 3'b100, 32'h0000_0101, 32'h0,        0, 32'h0000_8000, 32'h0,        4'b1111, 1, 2, 0, 32'h0000_0080);
    drain();
    issue(1, 0, 3'b101, 32'h0000_0102, 32'h0,        0, 32'hBEEF_0000, 32'h0,        4'b1111, 1, 2, 0, 32'h0000_BEEF);
    drain();
    issue(1, 0, 3'b001, 32'h0000_0102, 32'h0,        0, 32'hBEEF_0000, 32'h0,        4'b1111, 1, 2, 0, 32'hFFFF_BEEF);
    drain();
    issue(1, 0, 3'b010, 32'h0000_0104, 32'h0,        1, 32'h1234_5678, 32'h0,        4'b1111, 2, 3, 0, 32'h1234_5678);
    drain();
    issue(0, 1, 3'b001, 32'h0000_0106, 32'h0000_CAFE, 0, 32'h0,        32'hCAFE_CAFE, 4'b1100, 1, 2, 0, 32'h0);
    drain();
    // Rejected requests: misaligned word/half, LD+ST, out of range, illegal funct3.
    issue(1, 0, 3'b010, 32'h0000_0102, 32'h0,        0, 32'h0,        32'h0,        4'b0,    0, 1, 1, 32'h0);
    drain();
    issue(1, 1, 3'b010, 32'h0000_0100, 32'h0,        0, 32'h0,        32'h0,        4'b0,    0, 1, 1, 32'h0);
    drain();
    issue(1, 0, 3'b010, 32'h0004_0000, 32'h0,        0, 32'h0,        32'h0,        4'b0,    0, 1, 1, 32'h0);
    drain();
    issue(0, 1, 3'b001, 32'h0000_0101, 32'h0,        0, 32'h0,        32'h0,        4'b0,    0, 1, 1, 32'h0);
    drain();
    issue(1, 0, 3'b011, 32'h0000_0100, 32'h0,        0, 32'h0,        32'h0,        4'b0,    0, 1, 1, 32'h0);
    drain();
    issue(0, 1, 3'b100, 32'h0000_0100, 32'h0,        0, 32'h0,        32'h0,        4'b0,    0, 1, 1, 32'h0);
    drain();
    // Timeout, then a normal load.
    issue(1, 0, 3'b010, 32'h0000_0200, 32'h0,      100, 32'h0,        32'h0,        4'b1111, 4, 5, 1, 32'h0);
    drain();
    issue(1, 0, 3'b010, 32'h0000_0204, 32'h0,        0, 32'hA5A5_5A5A, 32'h0,        4'b1111, 1, 2, 0, 32'hA5A5_5A5A);
    drain();
    // Asynchronous reset in the middle of REQ.
    issue(1, 0, 3'b010, 32'h0000_0300, 32'h0,      100, 32'h0,        32'h0,        4'b1111, 2, 0, 0, 32'h0);
    @(negedge i_clk);
    #2 i_rst_n = 0;
    #1 chk("async_valid_drop", o_MEM_VALID, 0);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1;
    #1 chk_all_zero("post_reset");
    drain();
    issue(0, 1, 3'b010, 32'h0000_0010, 32'h0BAD_F00D, 0, 32'h0,        32'h0BAD_F00D, 4'b1111, 1, 2, 0, 32'h0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
